// File: rtl/gpa_fhdo_sequencer.sv
// gpa_fhdo_sequencer
//
// Purpose:
//   Takes one four-channel gradient update (x, y, z, z2). Sends each enabled
//   channel to gpa_fhdo_iface as one 32-bit word, paced against the interface's
//   busy line. The last enabled channel of a set carries the DAC update flag.
//   One further set can be posted at any time into a pending buffer; a newer
//   post overwrites an unconsumed pending set and is counted as an overrun.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   load_i         one-cycle strobe posting the set on val*_i / mask_i
//   mask_i[3:0]    per-channel enable, bit n enables channel n
//   valx_i..valz2_i channel 0..3 values (16 bit)
//   iface_busy_i   busy_o of gpa_fhdo_iface
//   iface_data_o   data word to the interface (holds when valid is low)
//   iface_valid_o  one-cycle word strobe to the interface
//   busy_o         high while a set is active or pending
//   done_o         one-cycle pulse after the last word of a set is accepted
//   overrun_cnt_o  saturating count of overwritten pending sets
//
// Word format: [31:27]=0, [26:25]=channel, [24]=update flag,
//              [23:16]=DAC_REG_BASE+channel, [15:0]=value

module gpa_fhdo_sequencer #(
    parameter logic [7:0] DAC_REG_BASE = 8'h08,
    parameter int         GUARD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [3:0]  mask_i,
    input  logic [15:0] valx_i,
    input  logic [15:0] valy_i,
    input  logic [15:0] valz_i,
    input  logic [15:0] valz2_i,
    input  logic        iface_busy_i,
    output logic [31:0] iface_data_o,
    output logic        iface_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  overrun_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        ISSUE,
        GUARD,
        WAIT
    } state_t;

    state_t           state;

    // Pending (posted, not yet started) set
    logic             pend_full;
    logic [3:0]       pend_mask;
    logic [3:0][15:0] pend_val;

    // Active set: channels still to be sent and their values
    logic [3:0]       remaining;
    logic [3:0][15:0] act_val;
    logic [1:0]       ptr;
    logic [2:0]       guard_cnt;

    // Derived, combinational from registers and inputs
    logic             consume;
    logic             post;
    logic [3:0]       rem_after;
    logic             last_word;
    logic [31:0]      word;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block can leave one unassigned and infer a latch.
        consume   = 1'b0;
        post      = 1'b0;
        rem_after = remaining & ~(4'b0001 << ptr);
        last_word = 1'b0;
        word      = '0;

        consume   = (state == IDLE) && pend_full;
        post      = load_i && (mask_i != 4'b0000);
        // The update flag goes on the word that empties the remaining set,
        // i.e. the highest-index enabled channel.
        last_word = (rem_after == 4'b0000);
        word      = {5'b00000, ptr, last_word, DAC_REG_BASE + {6'b000000, ptr}, act_val[ptr]};
    end

    assign busy_o = (state != IDLE) || pend_full;

    // NOTE: all state below uses non-blocking assignments, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pend_full     <= 1'b0;
            pend_mask     <= '0;
            pend_val      <= '0;
            remaining     <= '0;
            act_val       <= '0;
            ptr           <= '0;
            guard_cnt     <= '0;
            iface_data_o  <= '0;
            iface_valid_o <= 1'b0;
            done_o        <= 1'b0;
            overrun_cnt_o <= '0;
        end else begin
            iface_valid_o <= 1'b0;
            done_o        <= 1'b0;

            // Pending buffer. A post in the cycle IDLE consumes the buffer
            // lands after the consume, so it is not an overrun.
            if (post) begin
                pend_full <= 1'b1;
                pend_mask <= mask_i;
                pend_val  <= {valz2_i, valz_i, valy_i, valx_i};
                if (pend_full && !consume && (overrun_cnt_o != 8'hFF))
                    overrun_cnt_o <= overrun_cnt_o + 8'd1;
            end else if (consume) begin
                pend_full <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pend_full) begin
                        remaining <= pend_mask;
                        act_val   <= pend_val;
                        state     <= SEL;
                    end
                end
                SEL: begin
                    ptr   <= lowest_set(remaining);
                    state <= ISSUE;
                end
                ISSUE: begin
                    if (!iface_busy_i) begin
                        iface_valid_o <= 1'b1;
                        iface_data_o  <= word;
                        remaining     <= rem_after;
                        guard_cnt     <= '0;
                        state         <= GUARD;
                    end
                end
                GUARD: begin
                    // busy_i is ignored here: the interface needs a few cycles
                    // after valid before its busy line reflects the new word.
                    if (guard_cnt == 3'(GUARD_CYCLES - 1))
                        state <= WAIT;
                    else
                        guard_cnt <= guard_cnt + 3'd1;
                end
                WAIT: begin
                    if (!iface_busy_i) begin
                        if (remaining != 4'b0000) begin
                            state <= SEL;
                        end else begin
                            done_o <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
